// File: rtl/sd_spi_card_responder_if.sv
// SPI link between an SD host (master) and the card-side responder (slave).
interface sd_spi_card_responder_if;
  logic sck;
  logic cs_n;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output sck, output cs_n, output mosi, input miso, input miso_oe);
  modport slave  (input sck, input cs_n, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/sd_spi_card_responder.sv
// Card-side SD SPI-mode responder: deframes commands, answers R1/R7, and
// serves 512-byte blocks from a byte-wide synchronous memory for CMD17.
module sd_spi_card_responder #(
  parameter int MEM_AW      = 20,
  parameter int RESP_DELAY  = 1,
  parameter int TOKEN_DELAY = 2,
  parameter int INIT_POLLS  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  sd_spi_card_responder_if.slave spi,
  output logic [MEM_AW-1:0]      mem_addr,
  output logic                   mem_rd,
  input  logic [7:0]             mem_rdata,
  output logic                   card_ready,
  output logic [5:0]             last_cmd,
  output logic [15:0]            blocks_served
);
  localparam int         BLK_W      = MEM_AW - 9;
  localparam logic [7:0] RESP_FILL  = 8'(RESP_DELAY - 1);
  localparam logic [7:0] TOKEN_FILL = 8'(TOKEN_DELAY - 1);
  localparam logic [7:0] POLL_LIMIT = 8'(INIT_POLLS);

  typedef enum logic [2:0] {CMD_WAIT, CMD_RX, RESP, DATA_WAIT, DATA, CRC} state_t;

  logic sck_p0, sck_p1, sck_p2, cs_n_p0, cs_n_p1, mosi_p0, mosi_p1;
  logic sck_rise, sck_fall;

  state_t             state;
  logic [2:0]         bit_cnt, arg_cnt, resp_len;
  logic [7:0]         rx_shift, tx_shift, next_byte, data_buf, fill_cnt, tok_cnt, poll_cnt;
  logic               byte_done, rd_q, tok_sent, data_phase, crc_first, idle, app_cmd, oe_r;
  logic [5:0]         cmd;
  logic [31:0]        arg;
  logic [39:0]        resp_q;
  logic [BLK_W-1:0]   blk;
  logic [9:0]         byte_idx;

  logic [7:0]  dec_r1, dec_poll;
  logic [39:0] dec_q;
  logic [2:0]  dec_len;
  logic        dec_data, dec_idle, dec_ready, dec_app, arg_oob;

  // Input stage: two-flop synchronizers, third sck flop for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {sck_p0, sck_p1, sck_p2} <= 3'b000;
      {cs_n_p0, cs_n_p1}       <= 2'b11;
      {mosi_p0, mosi_p1}       <= 2'b11;
    end else begin
      {sck_p0, sck_p1, sck_p2} <= {spi.sck, sck_p0, sck_p1};
      {cs_n_p0, cs_n_p1}       <= {spi.cs_n, cs_n_p0};
      {mosi_p0, mosi_p1}       <= {spi.mosi, mosi_p0};
    end
  end

  assign sck_rise    = sck_p1 & ~sck_p2;
  assign sck_fall    = ~sck_p1 & sck_p2;
  assign spi.miso    = tx_shift[7];
  assign spi.miso_oe = oe_r;
  assign arg_oob     = (arg >> BLK_W) != 32'd0;

  always_comb begin
    dec_r1    = {5'b0, 1'b1, 1'b0, idle};
    dec_len   = 3'd1;
    dec_data  = 1'b0;
    dec_idle  = idle;
    dec_ready = card_ready;
    dec_app   = 1'b0;
    dec_poll  = poll_cnt;
    case (cmd)
      6'd0: begin
        dec_idle  = 1'b1;
        dec_ready = 1'b0;
        dec_poll  = 8'd0;
        dec_r1    = 8'h01;
      end
      6'd8: begin
        dec_r1  = {7'b0, idle};
        dec_len = 3'd5;
      end
      6'd55: begin
        dec_app = 1'b1;
        dec_r1  = {7'b0, idle};
      end
      6'd41: if (app_cmd) begin
        if (poll_cnt < POLL_LIMIT) begin
          dec_poll = poll_cnt + 8'd1;
          dec_r1   = 8'h01;
        end else begin
          dec_idle  = 1'b0;
          dec_ready = 1'b1;
          dec_r1    = 8'h00;
        end
      end
      6'd16: dec_r1 = {7'b0, idle};
      6'd17: begin
        if (idle)         dec_r1 = 8'h05;
        else if (arg_oob) dec_r1 = 8'h20;
        else begin
          dec_r1   = 8'h00;
          dec_data = 1'b1;
        end
      end
      default: ;
    endcase
    dec_q = (cmd == 6'd8) ? {dec_r1, 16'h0000, 8'h01, arg[7:0]} : {dec_r1, 32'hFFFF_FFFF};
  end

  // Bit stage and byte-level FSM; next_byte is resolved one clk after a byte completes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CMD_WAIT;
      bit_cnt <= '0; arg_cnt <= '0; resp_len <= '0;
      rx_shift <= 8'h00; tx_shift <= 8'hFF; next_byte <= 8'hFF; data_buf <= 8'h00;
      fill_cnt <= '0; tok_cnt <= '0; poll_cnt <= '0;
      byte_done <= 1'b0; rd_q <= 1'b0; tok_sent <= 1'b0; data_phase <= 1'b0; crc_first <= 1'b0;
      idle <= 1'b1; app_cmd <= 1'b0; oe_r <= 1'b0;
      cmd <= '0; arg <= '0; resp_q <= '0; blk <= '0; byte_idx <= '0;
      mem_addr <= '0; mem_rd <= 1'b0;
      card_ready <= 1'b0; last_cmd <= '0; blocks_served <= '0;
    end else if (cs_n_p1) begin
      bit_cnt   <= '0;
      tx_shift  <= 8'hFF;
      next_byte <= 8'hFF;
      state     <= CMD_WAIT;
      mem_rd    <= 1'b0;
      rd_q      <= 1'b0;
      byte_done <= 1'b0;
      oe_r      <= 1'b0;
    end else begin
      oe_r      <= 1'b1;
      mem_rd    <= 1'b0;
      rd_q      <= mem_rd;
      byte_done <= 1'b0;
      if (rd_q) data_buf <= mem_rdata;
      if (sck_rise) begin
        rx_shift <= {rx_shift[6:0], mosi_p1};
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) byte_done <= 1'b1;
      end
      if (sck_fall) tx_shift <= (bit_cnt == 3'd0) ? next_byte : {tx_shift[6:0], 1'b1};
      if (byte_done) begin
        case (state)
          CMD_WAIT: begin
            next_byte <= 8'hFF;
            if (rx_shift[7:6] == 2'b01) begin
              cmd     <= rx_shift[5:0];
              arg_cnt <= '0;
              state   <= CMD_RX;
            end
          end
          CMD_RX: begin
            next_byte <= 8'hFF;
            if (arg_cnt != 3'd4) begin
              arg     <= {arg[23:0], rx_shift};
              arg_cnt <= arg_cnt + 3'd1;
            end else begin
              last_cmd   <= cmd;
              idle       <= dec_idle;
              card_ready <= dec_ready;
              app_cmd    <= dec_app;
              poll_cnt   <= dec_poll;
              resp_q     <= dec_q;
              resp_len   <= dec_len;
              data_phase <= dec_data;
              blk        <= arg[BLK_W-1:0];
              fill_cnt   <= RESP_FILL;
              state      <= RESP;
            end
          end
          RESP: begin
            if (fill_cnt != 8'd0) begin
              fill_cnt  <= fill_cnt - 8'd1;
              next_byte <= 8'hFF;
            end else if (resp_len != 3'd0) begin
              next_byte <= resp_q[39:32];
              resp_q    <= {resp_q[31:0], 8'hFF};
              resp_len  <= resp_len - 3'd1;
            end else if (data_phase) begin
              state <= DATA_WAIT;
              if (TOKEN_DELAY == 0) begin
                next_byte <= 8'hFE;
                mem_rd    <= 1'b1;
                mem_addr  <= {blk, 9'd0};
                tok_sent  <= 1'b1;
              end else begin
                next_byte <= 8'hFF;
                tok_cnt   <= TOKEN_FILL;
                tok_sent  <= 1'b0;
              end
            end else begin
              next_byte <= 8'hFF;
              state     <= CMD_WAIT;
            end
          end
          DATA_WAIT: begin
            if (tok_sent) begin
              next_byte <= data_buf;
              mem_rd    <= 1'b1;
              mem_addr  <= {blk, 9'd1};
              byte_idx  <= 10'd1;
              state     <= DATA;
            end else if (tok_cnt != 8'd0) begin
              tok_cnt   <= tok_cnt - 8'd1;
              next_byte <= 8'hFF;
            end else begin
              next_byte <= 8'hFE;
              mem_rd    <= 1'b1;
              mem_addr  <= {blk, 9'd0};
              tok_sent  <= 1'b1;
            end
          end
          DATA: begin
            if (byte_idx != 10'd512) begin
              next_byte <= data_buf;
              byte_idx  <= byte_idx + 10'd1;
              if (byte_idx != 10'd511) begin
                mem_rd   <= 1'b1;
                mem_addr <= {blk, byte_idx[8:0] + 9'd1};
              end
            end else begin
              next_byte <= 8'h00;
              crc_first <= 1'b1;
              state     <= CRC;
            end
          end
          CRC: begin
            if (crc_first) begin
              next_byte <= 8'h00;
              crc_first <= 1'b0;
            end else begin
              next_byte     <= 8'hFF;
              blocks_served <= blocks_served + 16'd1;
              state         <= CMD_WAIT;
            end
          end
          default: state <= CMD_WAIT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sd_spi_card_responder.sv
// Bench for sd_spi_card_responder: SPI host driver, behavioural card model and
// a miso byte scoreboard fed by the driver and drained by an sck-edge monitor.
module tb_sd_spi_card_responder;
  localparam int MEM_AW      = 20;
  localparam int RESP_DELAY  = 1;
  localparam int TOKEN_DELAY = 2;
  localparam int INIT_POLLS  = 2;
  localparam int HALF        = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sd_spi_card_responder_if spi();
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_rdata = 8'h00;
  logic              card_ready;
  logic [5:0]        last_cmd;
  logic [15:0]       blocks_served;

  sd_spi_card_responder #(
    .MEM_AW(MEM_AW), .RESP_DELAY(RESP_DELAY), .TOKEN_DELAY(TOKEN_DELAY), .INIT_POLLS(INIT_POLLS)
  ) dut (
    .clk(clk), .reset(reset), .spi(spi),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .card_ready(card_ready), .last_cmd(last_cmd), .blocks_served(blocks_served)
  );

  function automatic logic [7:0] mem_byte(input logic [MEM_AW-1:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  always @(posedge clk) if (mem_rd) mem_rdata <= mem_byte(mem_addr);

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: assembles each miso byte at host sampling edges and scores it
  logic [7:0] mon_sh = 8'h00;
  int mon_bits = 0;
  int mon_idx = 0;
  always @(posedge spi.cs_n) mon_bits = 0;
  always @(posedge spi.sck) begin
    if (!spi.cs_n) begin
      mon_sh = {mon_sh[6:0], spi.miso};
      mon_bits++;
      if (mon_bits == 8) begin
        mon_bits = 0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL miso_byte%0d unexpected actual=%0h", mon_idx, mon_sh);
        end else begin
          check($sformatf("miso_byte%0d", mon_idx), {24'h0, mon_sh}, {24'h0, exp_q.pop_front()});
        end
        mon_idx++;
      end
    end
  end

  // Card model
  bit          m_idle = 1'b1, m_app = 1'b0, m_ready = 1'b0, m_data = 1'b0;
  int          m_polls = 0;
  logic [5:0]  m_last = 6'd0;
  logic [15:0] m_blocks = 16'd0;
  logic [7:0]  resp[$];

  task automatic model_cmd(input logic [5:0] c, input logic [31:0] a);
    logic [7:0] r1;
    logic [MEM_AW-1:0] ad;
    resp.delete();
    m_data = 1'b0;
    r1 = 8'h04 | {7'b0, m_idle};
    case (c)
      6'd0:  begin m_idle = 1'b1; m_ready = 1'b0; m_polls = 0; r1 = 8'h01; end
      6'd8:  r1 = {7'b0, m_idle};
      6'd55: r1 = {7'b0, m_idle};
      6'd16: r1 = {7'b0, m_idle};
      6'd41: if (m_app) begin
        if (m_polls < INIT_POLLS) begin m_polls++; r1 = 8'h01; end
        else begin m_idle = 1'b0; m_ready = 1'b1; r1 = 8'h00; end
      end
      6'd17: begin
        if (m_idle) r1 = 8'h05;
        else if (a >= (32'd1 << (MEM_AW - 9))) r1 = 8'h20;
        else begin r1 = 8'h00; m_data = 1'b1; end
      end
      default: ;
    endcase
    m_app  = (c == 6'd55);
    m_last = c;
    for (int i = 0; i < RESP_DELAY; i++) resp.push_back(8'hFF);
    resp.push_back(r1);
    if (c == 6'd8) begin
      resp.push_back(8'h00); resp.push_back(8'h00); resp.push_back(8'h01); resp.push_back(a[7:0]);
    end
    if (m_data) begin
      for (int i = 0; i < TOKEN_DELAY; i++) resp.push_back(8'hFF);
      resp.push_back(8'hFE);
      for (int i = 0; i < 512; i++) begin
        ad = MEM_AW'(int'(a) * 512 + i);
        resp.push_back(mem_byte(ad));
      end
      resp.push_back(8'h00);
      resp.push_back(8'h00);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_byte(input logic [7:0] tx, input logic [7:0] req);
    exp_q.push_back(req);
    for (int i = 7; i >= 0; i--) begin
      spi.mosi = tx[i];
      wait_clk(HALF);
      spi.sck = 1'b1;
      wait_clk(HALF);
      spi.sck = 1'b0;
    end
  endtask

  task automatic cs_cycle();
    wait_clk(2 * HALF);
    spi.cs_n = 1'b1;
    wait_clk(16);
    spi.cs_n = 1'b0;
    wait_clk(16);
  endtask

  // abort_after < 0 runs the full exchange; otherwise a data-phase CMD17 is cut after that many reply bytes
  task automatic send_cmd(input logic [5:0] c, input logic [31:0] a, input int abort_after);
    logic [7:0] crc;
    crc = (c == 6'd0) ? 8'h95 : (c == 6'd8) ? 8'h87 : 8'h01;
    model_cmd(c, a);
    spi_byte({2'b01, c}, 8'hFF);
    for (int i = 3; i >= 0; i--) spi_byte(a[8*i +: 8], 8'hFF);
    spi_byte(crc, 8'hFF);
    if (m_data && abort_after >= 0 && abort_after < resp.size()) begin
      for (int i = 0; i < abort_after; i++) spi_byte(8'hFF, resp[i]);
      cs_cycle();
    end else begin
      foreach (resp[i]) spi_byte(8'hFF, resp[i]);
      spi_byte(8'hFF, 8'hFF);
      if (m_data) m_blocks++;
    end
    wait_clk(4);
    check("last_cmd", {26'h0, last_cmd}, {26'h0, m_last});
    check("card_ready", {31'h0, card_ready}, {31'h0, m_ready});
    check("blocks_served", {16'h0, blocks_served}, {16'h0, m_blocks});
  endtask

  initial begin
    repeat (120000) @(posedge clk);
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    int pick;
    spi.sck = 1'b0; spi.cs_n = 1'b1; spi.mosi = 1'b1; reset = 1'b1;
    wait_clk(3);
    check("rst_miso", {31'h0, spi.miso}, 32'h1);
    check("rst_miso_oe", {31'h0, spi.miso_oe}, 32'h0);
    check("rst_mem_rd", {31'h0, mem_rd}, 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_card_ready", {31'h0, card_ready}, 32'h0);
    check("rst_last_cmd", {26'h0, last_cmd}, 32'h0);
    check("rst_blocks", {16'h0, blocks_served}, 32'h0);
    reset = 1'b0;
    wait_clk(4);
    spi.cs_n = 1'b0;
    wait_clk(8);
    check("miso_oe_cs_low", {31'h0, spi.miso_oe}, 32'h1);
    repeat (4) spi_byte(8'hFF, 8'hFF);
    check("card_ready_idle", {31'h0, card_ready}, 32'h0);

    send_cmd(6'd0, 32'h0, -1);
    send_cmd(6'd8, 32'h0000_01AA, -1);
    send_cmd(6'd17, 32'd3, -1);
    repeat (3) begin
      send_cmd(6'd55, 32'h0, -1);
      send_cmd(6'd41, 32'h4000_0000, -1);
    end
    check("card_ready_init", {31'h0, card_ready}, 32'h1);
    send_cmd(6'd17, 32'd3, -1);
    send_cmd(6'd17, 32'h800, -1);
    send_cmd(6'd17, 32'd5, RESP_DELAY + 1 + TOKEN_DELAY + 1 + 100);
    send_cmd(6'd17, 32'd0, -1);

    repeat (7) begin
      pick = $urandom_range(0, 8);
      case (pick)
        0: send_cmd(6'd8, $urandom, -1);
        1: send_cmd(6'd55, $urandom, -1);
        2: begin send_cmd(6'd55, 32'h0, -1); send_cmd(6'd41, $urandom, -1); end
        3: send_cmd(6'd41, $urandom, -1);
        4: send_cmd(6'd16, 32'd512, -1);
        5: send_cmd(6'($urandom_range(1, 7)), $urandom, -1);
        6: send_cmd(6'd17, 32'($urandom_range(0, 2047)),
                    RESP_DELAY + 1 + TOKEN_DELAY + 1 + $urandom_range(1, 3));
        7: send_cmd(6'd17, 32'd2048 + 32'($urandom_range(0, 100000)), -1);
        default: send_cmd(6'd0, 32'h0, -1);
      endcase
    end

    wait_clk(8);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
